fetch_queue: RTL

Instruction fetch queue between the instruction-fetch stage and the decode stage. Captures each fetched {PC+4, instruction} pair into a small circular FIFO so fetch can keep running while decode stalls, and presents entries to decode in program order under a valid/ready handshake. A redirect (jump, jr or taken branch resolved downstream) flushes every queued entry in one cycle.

---
 rtl/fetch_queue.sv | 105 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular FIFO of {pc+4, inst} pairs between fetch and decode.
// Define FETCHQ_BYPASS_EN to pass a fetched pair straight through an empty queue.
module fetch_queue #(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [31:0]   in_pcp4,
    input  logic [31:0]   in_inst,
    output logic          in_ready,
    input  logic          flush,
    output logic          out_valid,
    output logic [31:0]   out_pcp4,
    output logic [31:0]   out_inst,
    input  logic          out_ready,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;

    logic        empty;
    logic        byp;
    logic        push;
    logic        pop;
    logic        wr;
    logic        rd;
    logic [63:0] head;

    always_comb begin
        empty    = (count_q == '0);
        in_ready = (count_q != CW'(DEPTH));
        head     = mem_q[rp_q];
`ifdef FETCHQ_BYPASS_EN
        byp = empty & in_valid & ~flush;
`else
        byp = 1'b0;
`endif
        out_valid = ~empty | byp;
        out_pcp4  = 32'h0;
        out_inst  = 32'h0;
        if (byp) begin
            out_pcp4 = in_pcp4;
            out_inst = in_inst;
        end else if (!empty) begin
            out_pcp4 = head[63:32];
            out_inst = head[31:0];
        end
        push = in_valid & in_ready & ~flush;
        pop  = out_valid & out_ready & ~flush;
        // A bypassed pair that decode takes never touches the array
        wr   = push & ~(byp & out_ready);
        rd   = pop & ~byp;
        count = count_q;
    end

    always_comb begin
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (wr) begin
            mem_d[wp_q] = {in_pcp4, in_inst};
            wp_d        = wp_q + 1'b1;
        end
        if (rd) begin
            rp_d = rp_q + 1'b1;
        end
        case ({wr, rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
